// File: rtl/hattrick_i2c_pkg.sv
// rtl/hattrick_i2c_pkg.sv - shared types and constants for the I2C GPI slave
// Holds the protocol state enum, the ACK/NACK bit values and the depth of the
// pin synchronizer chain.
package hattrick_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_FETCH,
        ST_RD_BYTE,
        ST_RD_ACK
    } i2c_state_t;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_gpi_slave_if.sv
// rtl/i2c_gpi_slave_if.sv - I2C pin and GPI bank signal bundle
// I2C side : SCL_IN, SDA_IN raw pins; SDA_OE open-drain pull-down enable.
// Bank side: PORT_CS fetch pulse, OFFSET_SEL one-hot, RD_WR, RD_DATA byte.
// Write side: WR_DATA / WR_ADDR qualified by the one-cycle WR_STB.
interface i2c_gpi_slave_if;

    logic        SCL_IN;
    logic        SDA_IN;
    logic        SDA_OE;
    logic        PORT_CS;
    logic [15:0] OFFSET_SEL;
    logic        RD_WR;
    logic [7:0]  RD_DATA;
    logic [7:0]  WR_DATA;
    logic [7:0]  WR_ADDR;
    logic        WR_STB;

    modport slave (
        input  SCL_IN, SDA_IN, RD_DATA,
        output SDA_OE, PORT_CS, OFFSET_SEL, RD_WR, WR_DATA, WR_ADDR, WR_STB
    );

    modport master (
        output SCL_IN, SDA_IN, RD_DATA,
        input  SDA_OE, PORT_CS, OFFSET_SEL, RD_WR, WR_DATA, WR_ADDR, WR_STB
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - pin synchronizer with rise/fall pulse outputs
// Ports: SYSCLK, RESET_N (async, active-low); async_in raw pin;
//        sync_out synchronized level; rise/fall one-cycle edge pulses.
module i2c_sync_edge
    import hattrick_i2c_pkg::*;
(
    input  logic SYSCLK,
    input  logic RESET_N,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  hist_q;

    // Reset to the idle-high bus level so reset release never fakes an edge.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
            hist_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign sync_out = sync_q[SYNC_DEPTH-1];
    assign rise     = sync_out & ~hist_q;
    assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/i2c_gpi_slave.sv
// rtl/i2c_gpi_slave.sv - I2C slave front end for one port of the GPI read bank
// Params: DEV_ADDR 7-bit device address; PORT_PAGE pointer page mapped to the bank.
// Ports : SYSCLK, RESET_N (async, active-low); bus (i2c_gpi_slave_if.slave)
//         carrying the I2C pins, the bank fetch controls and the write strobe.
module i2c_gpi_slave
    import hattrick_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter logic [3:0] PORT_PAGE = 4'h0
) (
    input  logic             SYSCLK,
    input  logic             RESET_N,
    i2c_gpi_slave_if.slave   bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .SYSCLK   (SYSCLK),
        .RESET_N  (RESET_N),
        .async_in (bus.SCL_IN),
        .sync_out (scl_lvl),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .SYSCLK   (SYSCLK),
        .RESET_N  (RESET_N),
        .async_in (bus.SDA_IN),
        .sync_out (sda_lvl),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic       wr_stb_q, wr_stb_d;

    logic       page_hit;
    logic [7:0] shifted;
    assign page_hit = (ptr_q[7:4] == PORT_PAGE);
    assign shifted  = {shreg_q[6:0], sda_lvl};

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            shreg_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            ptr_q     <= 8'h00;
            sda_oe_q  <= 1'b0;
            fcnt_q    <= 2'd0;
            wr_data_q <= 8'h00;
            wr_addr_q <= 8'h00;
            wr_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            fcnt_q    <= fcnt_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        fcnt_d    = fcnt_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_stb_d  = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_WR_PTR, ST_WR_BYTE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Data byte is complete on the 8th rise; strobe it out
                        // before the ACK so the write side sees it early.
                        if (state_q == ST_WR_BYTE && bit_cnt_q == 4'd7) begin
                            wr_data_d = shifted;
                            wr_addr_d = ptr_q;
                            wr_stb_d  = 1'b1;
                            ptr_d     = ptr_q + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            if (shreg_q[7:1] == DEV_ADDR) begin
                                sda_oe_d = 1'b1;
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                state_d  = ST_IDLE;
                            end
                        end else begin
                            if (state_q == ST_WR_PTR)
                                ptr_d = shreg_q;
                            sda_oe_d = 1'b1;
                            state_d  = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        fcnt_d   = 2'd0;
                        state_d  = shreg_q[0] ? ST_RD_FETCH : ST_WR_PTR;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end
                ST_RD_FETCH: begin
                    // fcnt 0 is the fetch cycle; bank DOUT is registered, so
                    // it is sampled two cycles later.
                    fcnt_d = fcnt_q + 2'd1;
                    if (fcnt_q == 2'd2) begin
                        shreg_d   = page_hit ? bus.RD_DATA : 8'h00;
                        sda_oe_d  = page_hit ? ~bus.RD_DATA[7] : 1'b1;
                        ptr_d     = ptr_q + 8'd1;
                        bit_cnt_d = 4'd1;
                        state_d   = ST_RD_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK)
                            state_d = ST_IDLE;
                    end else if (scl_fall) begin
                        fcnt_d  = 2'd0;
                        state_d = ST_RD_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    logic fetch_cyc;
    assign fetch_cyc      = (state_q == ST_RD_FETCH) && (fcnt_q == 2'd0);
    assign bus.PORT_CS    = fetch_cyc & page_hit;
    assign bus.OFFSET_SEL = bus.PORT_CS ? (16'h0001 << ptr_q[3:0]) : 16'h0000;
    assign bus.RD_WR      = 1'b1;
    assign bus.SDA_OE     = sda_oe_q;
    assign bus.WR_DATA    = wr_data_q;
    assign bus.WR_ADDR    = wr_addr_q;
    assign bus.WR_STB     = wr_stb_q;

endmodule

// File: tb/tb_i2c_gpi_slave.sv
// tb/tb_i2c_gpi_slave.sv - directed bench for i2c_gpi_slave
module tb_i2c_gpi_slave;

    logic SYSCLK  = 1'b0;
    logic RESET_N = 1'b0;
    logic scl_m   = 1'b1;
    logic sda_m   = 1'b1;

    logic [7:0] din [16];
    logic [7:0] bank_q = 8'h00;

    int total = 0;
    int bad   = 0;

    int          cs_cnt    = 0;
    int          stb_cnt   = 0;
    int          stray_off = 0;
    int          oe_cnt    = 0;
    logic [15:0] last_off  = 16'h0;
    logic [7:0]  stb_addr [4];
    logic [7:0]  stb_data [4];

    i2c_gpi_slave_if bus ();

    assign bus.SCL_IN  = scl_m;
    assign bus.SDA_IN  = sda_m & ~bus.SDA_OE;
    assign bus.RD_DATA = bank_q;

    i2c_gpi_slave #(
        .DEV_ADDR  (7'h50),
        .PORT_PAGE (4'h0)
    ) dut (
        .SYSCLK  (SYSCLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    function automatic int onehot_idx(input logic [15:0] v);
        int r = 0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = i;
        return r;
    endfunction

    // Registered bank: DOUT follows a fetch by one clock.
    always @(posedge SYSCLK)
        if (bus.PORT_CS) bank_q <= din[onehot_idx(bus.OFFSET_SEL)];

    always @(negedge SYSCLK) begin
        if (bus.PORT_CS) begin
            cs_cnt   = cs_cnt + 1;
            last_off = bus.OFFSET_SEL;
        end
        if (!bus.PORT_CS && bus.OFFSET_SEL != 16'h0)
            stray_off = stray_off + 1;
        if (bus.WR_STB) begin
            if (stb_cnt < 4) begin
                stb_addr[stb_cnt] = bus.WR_ADDR;
                stb_data[stb_cnt] = bus.WR_DATA;
            end
            stb_cnt = stb_cnt + 1;
        end
        if (bus.SDA_OE)
            oe_cnt = oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(negedge SYSCLK);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic wbit(input logic b);
        sda_m = b;    q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = bus.SDA_IN; q();
        scl_m = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(ack);
    endtask

    task automatic recv_byte(input logic ackb, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        wbit(ackb);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d1, d2, d3;
        int         cs0, oe0;

        for (int i = 0; i < 16; i++) din[i] = 8'h00;
        din[0]  = 8'h96;
        din[1]  = 8'h3C;
        din[3]  = 8'hA5;
        din[5]  = 8'h5A;
        din[14] = 8'h11;
        din[15] = 8'h22;

        repeat (3) @(negedge SYSCLK);
        check("rst_sda_oe",  {31'd0, bus.SDA_OE},  32'd0);
        check("rst_port_cs", {31'd0, bus.PORT_CS}, 32'd0);
        check("rst_offset",  {16'd0, bus.OFFSET_SEL}, 32'h0);
        check("rst_rd_wr",   {31'd0, bus.RD_WR},   32'd1);
        check("rst_wr_stb",  {31'd0, bus.WR_STB},  32'd0);
        check("rst_wr_data", {24'd0, bus.WR_DATA}, 32'h00);
        check("rst_wr_addr", {24'd0, bus.WR_ADDR}, 32'h00);
        RESET_N = 1'b1;
        q();

        // Wrong address: no ACK, no drive, no fetch.
        cs0 = cs_cnt; oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, ack);
        check("bad_addr_nack", {31'd0, ack}, 32'd1);
        check("bad_addr_no_oe", oe_cnt - oe0, 0);
        i2c_stop();
        check("bad_addr_no_cs", cs_cnt - cs0, 0);

        // Pointer 0x03, repeated START, single-byte read.
        cs0 = cs_cnt;
        i2c_start();
        send_byte(8'hA0, ack); check("t2_addr_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h03, ack); check("t2_ptr_ack",  {31'd0, ack}, 32'd0);
        i2c_start();
        send_byte(8'hA1, ack); check("t2_raddr_ack", {31'd0, ack}, 32'd0);
        recv_byte(1'b1, d1);
        i2c_stop();
        check("t2_data",   {24'd0, d1}, 32'hA5);
        check("t2_cs_cnt", cs_cnt - cs0, 1);
        check("t2_offset", {16'd0, last_off}, 32'h0008);

        // Pointer 0x0E, three-byte read crossing into the unmapped page.
        cs0 = cs_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0E, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b0, d1);
        recv_byte(1'b0, d2);
        recv_byte(1'b1, d3);
        i2c_stop();
        check("t3_byte0",  {24'd0, d1}, 32'h11);
        check("t3_byte1",  {24'd0, d2}, 32'h22);
        check("t3_byte2",  {24'd0, d3}, 32'h00);
        check("t3_cs_cnt", cs_cnt - cs0, 2);
        check("t3_offset", {16'd0, last_off}, 32'h8000);

        // Two data writes at pointer 0x20.
        cs0 = cs_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h20, ack);
        send_byte(8'h7E, ack); check("t4_d0_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h7F, ack); check("t4_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("t4_stb_cnt", stb_cnt, 2);
        check("t4_addr0", {24'd0, stb_addr[0]}, 32'h20);
        check("t4_data0", {24'd0, stb_data[0]}, 32'h7E);
        check("t4_addr1", {24'd0, stb_addr[1]}, 32'h21);
        check("t4_data1", {24'd0, stb_data[1]}, 32'h7F);
        check("t4_no_cs", cs_cnt - cs0, 0);

        // STOP after four data bits, then read at the current pointer.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop();
        check("t5_sda_oe",  {31'd0, bus.SDA_OE}, 32'd0);
        check("t5_stb_cnt", stb_cnt, 2);
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d1);
        i2c_stop();
        check("t5_data",   {24'd0, d1}, 32'h5A);
        check("t5_offset", {16'd0, last_off}, 32'h0020);

        // Reset while the slave drives a 0 data bit.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        for (int i = 0; i < 40 && !bus.SDA_OE; i++) @(negedge SYSCLK);
        check("t6_oe_driving", {31'd0, bus.SDA_OE}, 32'd1);
        RESET_N = 1'b0;
        #1;
        check("t6_rst_sda_oe",  {31'd0, bus.SDA_OE},  32'd0);
        check("t6_rst_port_cs", {31'd0, bus.PORT_CS}, 32'd0);
        check("t6_rst_offset",  {16'd0, bus.OFFSET_SEL}, 32'h0);
        repeat (3) @(negedge SYSCLK);
        RESET_N = 1'b1;
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack); check("t6_addr_ack", {31'd0, ack}, 32'd0);
        recv_byte(1'b1, d1);
        i2c_stop();
        check("t6_data",   {24'd0, d1}, 32'h96);
        check("t6_offset", {16'd0, last_off}, 32'h0001);

        check("stray_offset", stray_off, 0);
        check("final_stb_cnt", stb_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_gpi_slave.md
# i2c_gpi_slave

I2C slave front end that sits directly upstream of the dual-port GPI read bank. It decodes I2C transactions from one bus into that bank's port-select, one-hot offset-select and read/write controls, and returns the bank's registered read byte to the master. Two instances, one per I2C bus, drive the bank's port 1 and port 2. Write bytes are forwarded on a strobe interface for a write-side sibling block.

## Interface
- DEV_ADDR, 7'h50: 7-bit I2C device address this slave acknowledges.
- PORT_PAGE, 4'h0: pointer upper nibble that maps onto the GPI bank.
- SYSCLK  in  1  system clock; must be at least 20× the SCL frequency.
- RESET_N  in  1  reset; asynchronous, active-low.
- SCL_IN  in  1  raw SCL pin.
- SDA_IN  in  1  raw SDA pin.
- SDA_OE  out  1  1 pulls SDA low (open-drain); reset 0.
- PORT_CS  out  1  one-cycle fetch pulse to the GPI bank; reset 0.
- OFFSET_SEL  out  16  one-hot of pointer[3:0], valid with PORT_CS; reset 16'h0.
- RD_WR  out  1  1 means read; held at 1 (writes never reach the GPI bank); reset 1.
- RD_DATA  in  8  GPI bank DOUT for this port.
- WR_DATA  out  8  last written data byte; reset 8'h00.
- WR_ADDR  out  8  pointer for WR_DATA; reset 8'h00.
- WR_STB  out  1  one-cycle write strobe; reset 0.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer plus one history flop. All edge and START/STOP detection uses the synchronized values.
- START: SDA falls while SCL is high. Valid in any state (including repeated START): go to ADDR and clear the bit counter.
- STOP: SDA rises while SCL is high. Valid in any state: go to IDLE, drop SDA_OE, keep the pointer.
- States: IDLE, ADDR, ADDR_ACK, WR_PTR, WR_BYTE, WR_ACK, RD_FETCH, RD_BYTE, RD_ACK.
- Bit sampling: on each SCL rise, shift SDA into an 8-bit register, MSB first.
- ADDR: after 8 bits, compare [7:1] with DEV_ADDR.
  - Mismatch: go to IDLE with no ACK and ignore the bus until the next START.
  - Match: go to ADDR_ACK and hold SDA_OE=1 from the 8th SCL fall to the 9th SCL fall.
  - Then go to WR_PTR if R/W=0, or RD_FETCH if R/W=1.
- WR_PTR: the first byte loads the pointer and is ACKed. Go to WR_BYTE.
- WR_BYTE: each subsequent byte is ACKed and produces:
  - WR_DATA = byte, WR_ADDR = pointer, WR_STB pulse on the 8th SCL rise;
  - then pointer+1.
- RD_FETCH: on entry, issue one fetch cycle F:
  - PORT_CS = (pointer[7:4]==PORT_PAGE) and OFFSET_SEL = 1<<pointer[3:0];
  - at cycle F+2, load the shift register from RD_DATA (8'h00 if the page does not match);
  - drive the MSB (SDA_OE = ~bit) and increment the pointer;
  - go to RD_BYTE.
- RD_BYTE: shift the next bit out on each SCL fall. After the 8th SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample the master's ACK on the 9th SCL rise.
  - ACK (0): go to RD_FETCH on the 9th SCL fall.
  - NACK (1): go to IDLE.
- The pointer is 8 bits and wraps 8'hFF→8'h00.
- A read with no preceding pointer write uses the current pointer.
- Reset mid-transaction: all outputs immediately take their reset values, the state is IDLE and the pointer is 8'h00.

## Timing
- Edge detect latency: 3 SYSCLK cycles from a pin edge to the internal event.
- SDA_OE updates 1 cycle after an internal SCL-fall event and is never changed while synchronized SCL is high, except on STOP/START release.
- Fetch-to-load is exactly 2 cycles, matching the GPI bank's registered DOUT (PORT_CS at F, DOUT valid at F+1, sampled at F+2).
- The first read bit is valid on SDA 6 SYSCLK cycles after the SCL fall, which is well within the SCL low time given the 20× clock ratio.
- PORT_CS and WR_STB never exceed 1 cycle per byte. OFFSET_SEL returns to 16'h0 after the fetch cycle.

## Structure
- Shared package hattrick_i2c_pkg holds:
  - the state enum;
  - the ACK/NACK constants;
  - the synchronizer depth constant (2).
- One sub-module, i2c_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs. Instantiated for SCL and SDA.

## Test plan
- Address 0x51 with DEV_ADDR=0x50 → no ACK (SDA_OE stays 0), no PORT_CS, next START is accepted normally.
- Write ptr 0x03, repeated START, read 1 byte with DIN3=0xA5 → one PORT_CS pulse with OFFSET_SEL=16'h0008, master receives 0xA5, NACK → IDLE.
- Pointer 0x0E, read 3 bytes with ACK, ACK, NACK and DIN14=0x11, DIN15=0x22 → bytes 0x11, 0x22, 0x00 (page 1 unmapped, PORT_CS not asserted on the 3rd fetch).
- Write ptr 0x20, data 0x7E, 0x7F → WR_STB twice with (WR_ADDR, WR_DATA) = (0x20, 0x7E), (0x21, 0x7F). PORT_CS is never asserted.
- STOP after 4 data bits of a write → IDLE, no WR_STB, SDA_OE=0, pointer unchanged.
- RESET_N low during RD_BYTE while SDA_OE=1 → SDA_OE, PORT_CS and OFFSET_SEL go to 0 immediately and the pointer is 8'h00.
